// File: rtl/rf_pkg.sv
// Shared constants for the parametrised register file: write-mode encodings
// and the default geometry used when the top is instantiated without overrides.
package rf_pkg;

  localparam int DEF_W    = 32;
  localparam int DEF_NREG = 4;

  localparam logic MODO_LOAD = 1'b0;
  localparam logic MODO_ACC  = 1'b1;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: range check, storage mux, write-first bypass
// against the value about to be written, and a resettable output register.
module rf_read_port #(
  parameter  int W    = 32,
  parameter  int NREG = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [AW-1:0]   fonte,
  input  logic [NREG*W-1:0] regs,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_idx,
  input  logic [W-1:0]    wr_value,
  output logic [W-1:0]    dado
);

  localparam logic [AW:0] NREG_V = (AW+1)'(NREG);

  logic         in_range_p0;
  logic [W-1:0] rd_value_p0;
  logic [W-1:0] dado_p1;

  // Stage p0: select stored word, overridden by the same-cycle write
  always_comb begin
    in_range_p0 = {1'b0, fonte} < NREG_V;
    rd_value_p0 = '0;
    if (in_range_p0) begin
      if (wr_en && (fonte == wr_idx)) begin
        rd_value_p0 = wr_value;
      end else begin
        rd_value_p0 = regs[int'(fonte)*W +: W];
      end
    end
  end

  // Stage p1: output register, cleared by reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      dado_p1 <= '0;
    end else begin
      dado_p1 <= rd_value_p0;
    end
  end

  assign dado = dado_p1;

endmodule

// File: rtl/param_register_file.sv
// NREG x W register file with load/accumulate write port, two registered
// write-first read ports, an accumulate carry pulse and a flat debug view.
module param_register_file
  import rf_pkg::*;
#(
  parameter  int W    = DEF_W,
  parameter  int NREG = DEF_NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Esc,
  input  logic              Modo,
  input  logic [AW-1:0]     RegEsc,
  input  logic [W-1:0]      Dado,
  input  logic [AW-1:0]     Fonte1,
  input  logic [AW-1:0]     Fonte2,
  output logic [W-1:0]      Dado1,
  output logic [W-1:0]      Dado2,
  output logic              Ovf,
  output logic [NREG*W-1:0] Regs
);

  localparam logic [AW:0] NREG_V = (AW+1)'(NREG);

  logic [W-1:0]      regs_q [NREG];
  logic [NREG*W-1:0] regs_flat;
  logic              wr_ok;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [W:0]        sum;
  logic [W-1:0]      wr_value;
  logic              ovf_q;

  // Stage p0: next value of the write target (load or wrapped sum with carry)
  always_comb begin
    wr_ok  = {1'b0, RegEsc} < NREG_V;
    wr_en  = Esc && wr_ok;
    wr_idx = wr_ok ? RegEsc : '0;
    sum    = {1'b0, regs_q[wr_idx]} + {1'b0, Dado};
    case (Modo)
      MODO_LOAD: wr_value = Dado;
      MODO_ACC:  wr_value = sum[W-1:0];
      default:   wr_value = Dado;
    endcase
  end

  // Stage p1: storage update; reset clears every register and drops the write
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_idx] <= wr_value;
    end
  end

  // Carry pulse: high for exactly the cycle after an overflowing accumulate
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= wr_en && (Modo == MODO_ACC) && sum[W];
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[g*W +: W] = regs_q[g];
  end

  rf_read_port #(.W(W), .NREG(NREG)) u_rd1 (
    .Clk      (Clk),
    .Rst      (Rst),
    .fonte    (Fonte1),
    .regs     (regs_flat),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_value (wr_value),
    .dado     (Dado1)
  );

  rf_read_port #(.W(W), .NREG(NREG)) u_rd2 (
    .Clk      (Clk),
    .Rst      (Rst),
    .fonte    (Fonte2),
    .regs     (regs_flat),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_value (wr_value),
    .dado     (Dado2)
  );

  assign Ovf  = ovf_q;
  assign Regs = regs_flat;

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: a 4-entry and a 3-entry instance share one
// stimulus bus (both have 2-bit addresses) and are checked every cycle against
// an array model, plus literal expectations for the directed scenarios.
module tb_param_register_file;

  logic        Clk;
  logic        Rst, Esc, Modo;
  logic [1:0]  RegEsc, Fonte1, Fonte2;
  logic [31:0] Dado;

  logic [31:0]  d1_4, d2_4, d1_3, d2_3;
  logic         ovf4, ovf3;
  logic [127:0] regs4;
  logic [95:0]  regs3;

  int checks = 0;
  int errors = 0;

  // Model state: index 0 is the 4-register instance, index 1 the 3-register one
  logic [31:0] mem   [2][4];
  logic [31:0] e_d1  [2];
  logic [31:0] e_d2  [2];
  logic        e_ovf [2];
  bit          chk_en = 0;

  param_register_file #(.W(32), .NREG(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .Esc(Esc), .Modo(Modo), .RegEsc(RegEsc), .Dado(Dado),
    .Fonte1(Fonte1), .Fonte2(Fonte2), .Dado1(d1_4), .Dado2(d2_4), .Ovf(ovf4), .Regs(regs4)
  );

  param_register_file #(.W(32), .NREG(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .Esc(Esc), .Modo(Modo), .RegEsc(RegEsc), .Dado(Dado),
    .Fonte1(Fonte1), .Fonte2(Fonte2), .Dado1(d1_3), .Dado2(d2_3), .Ovf(ovf3), .Regs(regs3)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Predict what the next clock edge must produce from the current inputs
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int          n;
      bit          wr;
      logic [31:0] cur, nv;
      logic [32:0] total;
      n = (k == 0) ? 4 : 3;
      if (Rst) begin
        for (int i = 0; i < 4; i++) mem[k][i] = 32'h0;
        e_d1[k]  = 32'h0;
        e_d2[k]  = 32'h0;
        e_ovf[k] = 1'b0;
      end else begin
        wr    = Esc && (int'(RegEsc) < n);
        cur   = (int'(RegEsc) < n) ? mem[k][RegEsc] : 32'h0;
        total = {1'b0, cur} + {1'b0, Dado};
        nv    = Modo ? total[31:0] : Dado;
        e_ovf[k] = wr && Modo && total[32];
        if (int'(Fonte1) >= n)           e_d1[k] = 32'h0;
        else if (wr && Fonte1 == RegEsc) e_d1[k] = nv;
        else                             e_d1[k] = mem[k][Fonte1];
        if (int'(Fonte2) >= n)           e_d2[k] = 32'h0;
        else if (wr && Fonte2 == RegEsc) e_d2[k] = nv;
        else                             e_d2[k] = mem[k][Fonte2];
        if (wr) mem[k][RegEsc] = nv;
      end
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit m, input logic [1:0] a,
                       input logic [31:0] dv, input logic [1:0] f1, input logic [1:0] f2);
    Rst = r; Esc = e; Modo = m; RegEsc = a; Dado = dv; Fonte1 = f1; Fonte2 = f2;
    model_step();
    chk_en = 1;
    @(negedge Clk);
    #1;
  endtask

  // Every-cycle comparison against the model
  initial begin
    logic [127:0] x4;
    logic [95:0]  x3;
    forever begin
      @(negedge Clk);
      if (chk_en) begin
        for (int i = 0; i < 4; i++) x4[i*32 +: 32] = mem[0][i];
        for (int i = 0; i < 3; i++) x3[i*32 +: 32] = mem[1][i];
        chk("n4_dado1", {96'h0, d1_4}, {96'h0, e_d1[0]});
        chk("n4_dado2", {96'h0, d2_4}, {96'h0, e_d2[0]});
        chk("n4_ovf",   {127'h0, ovf4}, {127'h0, e_ovf[0]});
        chk("n4_regs",  regs4, x4);
        chk("n3_dado1", {96'h0, d1_3}, {96'h0, e_d1[1]});
        chk("n3_dado2", {96'h0, d2_3}, {96'h0, e_d2[1]});
        chk("n3_ovf",   {127'h0, ovf3}, {127'h0, e_ovf[1]});
        chk("n3_regs",  {32'h0, regs3}, {32'h0, x3});
      end
    end
  end

  initial begin
    Rst = 1'b1; Esc = 1'b0; Modo = 1'b0; RegEsc = 2'd0; Dado = 32'h0; Fonte1 = 2'd0; Fonte2 = 2'd0;
    drive(1, 0, 0, 2'd0, 32'h0, 2'd0, 2'd0);

    // Reset clears preloaded contents
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 2'(i), 32'hFFFF_FFFF, 2'd0, 2'd0);
    chk("lit_preload_n4", regs4, {4{32'hFFFF_FFFF}});
    chk("lit_preload_n3", {32'h0, regs3}, {32'h0, {3{32'hFFFF_FFFF}}});
    drive(1, 0, 0, 2'd0, 32'h0, 2'd0, 2'd0);
    chk("lit_rst_regs", regs4, 128'h0);
    chk("lit_rst_d1", {96'h0, d1_4}, 128'h0);
    chk("lit_rst_d2", {96'h0, d2_4}, 128'h0);
    chk("lit_rst_ovf", {127'h0, ovf4}, 128'h0);

    // Load then read one cycle later
    drive(0, 1, 0, 2'd2, 32'h1234_5678, 2'd0, 2'd0);
    drive(0, 0, 0, 2'd0, 32'h0, 2'd2, 2'd0);
    chk("lit_load_d1", {96'h0, d1_4}, {96'h0, 32'h1234_5678});
    chk("lit_load_d2", {96'h0, d2_4}, 128'h0);

    // Accumulate with bypass
    drive(0, 1, 0, 2'd1, 32'd5, 2'd0, 2'd0);
    drive(0, 1, 1, 2'd1, 32'd3, 2'd1, 2'd0);
    chk("lit_byp_d1", {96'h0, d1_4}, {96'h0, 32'd8});
    chk("lit_byp_r1", {96'h0, regs4[63:32]}, {96'h0, 32'd8});

    // Wrap with carry pulse; R3 is out of range on the 3-entry instance
    drive(0, 1, 0, 2'd3, 32'hFFFF_FFFF, 2'd0, 2'd0);
    drive(0, 1, 1, 2'd3, 32'd2, 2'd3, 2'd0);
    chk("lit_wrap_r3", {96'h0, regs4[127:96]}, {96'h0, 32'h1});
    chk("lit_wrap_ovf", {127'h0, ovf4}, {127'h0, 1'b1});
    chk("lit_wrap_d1", {96'h0, d1_4}, {96'h0, 32'h1});
    chk("lit_n3_noovf", {127'h0, ovf3}, 128'h0);
    drive(0, 0, 0, 2'd0, 32'h0, 2'd0, 2'd0);
    chk("lit_ovf_drop", {127'h0, ovf4}, 128'h0);

    // Out-of-range write and read on the 3-entry instance
    drive(0, 1, 0, 2'd3, 32'hAA, 2'd3, 2'd1);
    chk("lit_rng_d1", {96'h0, d1_3}, 128'h0);
    chk("lit_rng_d2", {96'h0, d2_3}, {96'h0, 32'd8});
    chk("lit_rng_regs", {32'h0, regs3}, {32'h0, 32'h1234_5678, 32'd8, 32'd0});
    chk("lit_rng_n4", {96'h0, regs4[127:96]}, {96'h0, 32'hAA});

    // Exact wrap to zero
    drive(0, 1, 0, 2'd0, 32'hFFFF_FFFF, 2'd0, 2'd0);
    drive(0, 1, 1, 2'd0, 32'd1, 2'd0, 2'd0);
    chk("lit_zero_r0", {96'h0, regs4[31:0]}, 128'h0);
    chk("lit_zero_ovf", {127'h0, ovf4}, {127'h0, 1'b1});

    // Both ports on the write target
    drive(0, 1, 0, 2'd2, 32'hCAFE, 2'd2, 2'd2);
    chk("lit_dual_d1", {96'h0, d1_4}, {96'h0, 32'hCAFE});
    chk("lit_dual_d2", {96'h0, d2_4}, {96'h0, 32'hCAFE});
    chk("lit_dual_n3", {96'h0, d2_3}, {96'h0, 32'hCAFE});

    // Reset wins over a simultaneous write
    drive(0, 1, 0, 2'd0, 32'd7, 2'd0, 2'd0);
    chk("lit_pre_r0", {96'h0, regs4[31:0]}, {96'h0, 32'd7});
    drive(1, 1, 0, 2'd0, 32'd7, 2'd0, 2'd0);
    chk("lit_prio_regs", regs4, 128'h0);
    chk("lit_prio_d1", {96'h0, d1_4}, 128'h0);
    chk("lit_prio_d2", {96'h0, d2_4}, 128'h0);

    // Mixed traffic, checked by the model only
    for (int c = 0; c < 80; c++) begin
      logic [31:0] v;
      v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
      drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), v, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
